// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Contents: loader FSM state encoding, byte/word/timeout widths and the
// default frame start byte.
package imem_boot_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned TMO_W  = 24;
  localparam int unsigned CNT_W  = 8;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LO,
    HI,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/boot_byte_skid.sv
// One-entry byte holding register. It parks a UART byte that arrives while
// the loader cannot take it, until the loader pops it.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/in_data  store request and byte (a store wins over a pop)
//   pop             drop the held byte
//   out_valid/out_data  held byte
//   full            entry occupied
module boot_byte_skid #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              full
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Storing a new byte in the same cycle as a pop replaces the old one.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (in_valid) begin
      full_d = 1'b1;
      data_d = in_data;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;
  assign full      = full_q;

endmodule

// File: rtl/imem_boot_ctrl.sv
// Program BSRAM boot loader. Receives a framed image over UART bytes
// (SYNC_BYTE, LEN, LEN x {lo, hi}[, CSUM]), writes it word by word into the
// BSRAM, holds the CPU while loading, then restarts it at PC 0.
// Optional feature macro: IMEM_BOOT_CSUM_EN adds a trailing checksum byte
// (LEN + all data bytes, mod 256); mismatch leaves the CPU held in ERR.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rx_valid/rx_data  received UART byte strobe and value
//   cpu_pc          CPU fetch address
//   mem_ad/mem_din/mem_wre/mem_ce  BSRAM port (mem_ad is a live mux)
//   cpu_run         CPU enable; cpu_restart one-cycle PC-reset pulse
//   busy            frame in progress; err sticky frame error
//   words_loaded    words written in the last/current frame
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 11,
  parameter logic [BYTE_W-1:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter logic [TMO_W-1:0]   TIMEOUT   = 24'd270000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [WORD_W-1:0] mem_din,
  output logic              mem_wre,
  output logic              mem_ce,
  output logic              cpu_run,
  output logic              cpu_restart,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  words_loaded
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [BYTE_W-1:0]   lo_q, lo_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [CNT_W-1:0]    words_q, words_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                cpu_run_q, cpu_run_d;
  logic                cpu_restart_q, cpu_restart_d;
  logic                mem_wre_q, mem_wre_d;
`ifdef IMEM_BOOT_CSUM_EN
  logic [BYTE_W-1:0]   csum_q, csum_d;
`endif

  logic                skid_valid, skid_full;
  logic [BYTE_W-1:0]   skid_data;
  logic                can_accept_c, byte_valid_c, skid_push_c, skid_pop_c;
  logic                overflow_c, counting_c, tmo_hit_c;
  logic [BYTE_W-1:0]   byte_data_c;

  // Byte source: a parked byte always goes ahead of a fresh rx byte.
  always_comb begin
    can_accept_c = (state_q != WRITE) && (state_q != DONE);
    byte_valid_c = can_accept_c && (skid_valid || rx_valid);
    byte_data_c  = skid_valid ? skid_data : rx_data;
    skid_pop_c   = can_accept_c && skid_valid;
    skid_push_c  = rx_valid && (skid_valid ? can_accept_c : !can_accept_c);
    overflow_c   = rx_valid && skid_full && !can_accept_c;
    counting_c   = (state_q == LEN) || (state_q == LO) ||
                   (state_q == HI)  || (state_q == CSUM);
    tmo_hit_c    = (tmo_q >= (TIMEOUT - TMO_W'(1)));
  end

  boot_byte_skid #(
    .DATA_W (BYTE_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (skid_push_c),
    .in_data   (rx_data),
    .pop       (skid_pop_c),
    .out_valid (skid_valid),
    .out_data  (skid_data),
    .full      (skid_full)
  );

  // Loader FSM: next state, datapath updates and registered output decode.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    lo_d     = lo_q;
    word_d   = word_q;
    words_d  = words_q;
    tmo_d    = '0;
    err_d    = err_q;
`ifdef IMEM_BOOT_CSUM_EN
    csum_d   = csum_q;
`endif

    case (state_q)
      IDLE, ERR: begin
        if (byte_valid_c && (byte_data_c == SYNC_BYTE)) begin
          state_d = LEN;
          addr_d  = '0;
          words_d = '0;
          err_d   = 1'b0;
`ifdef IMEM_BOOT_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LEN: begin
        if (byte_valid_c) begin
          len_d   = byte_data_c;
          state_d = (byte_data_c == '0) ? IDLE : LO;
`ifdef IMEM_BOOT_CSUM_EN
          csum_d  = byte_data_c;
`endif
        end
      end
      LO: begin
        if (byte_valid_c) begin
          lo_d    = byte_data_c;
          state_d = HI;
`ifdef IMEM_BOOT_CSUM_EN
          csum_d  = csum_q + byte_data_c;
`endif
        end
      end
      HI: begin
        if (byte_valid_c) begin
          word_d  = {byte_data_c, lo_q};
          state_d = WRITE;
`ifdef IMEM_BOOT_CSUM_EN
          csum_d  = csum_q + byte_data_c;
`endif
        end
      end
      WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        words_d = words_q + CNT_W'(1);
        if (words_d == len_q) begin
`ifdef IMEM_BOOT_CSUM_EN
          state_d = CSUM;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = LO;
        end
      end
`ifdef IMEM_BOOT_CSUM_EN
      CSUM: begin
        if (byte_valid_c) begin
          state_d = (byte_data_c == csum_q) ? DONE : ERR;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Inter-byte timeout only runs while waiting for a frame byte.
    if (counting_c && !byte_valid_c) begin
      if (tmo_hit_c) begin
        state_d = ERR;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    if (overflow_c) begin
      state_d = ERR;
    end

    if (state_d == ERR) begin
      err_d = 1'b1;
    end

    // cpu_run rises on the same edge as the restart pulse.
    cpu_run_d     = (state_d == IDLE) || (state_d == DONE);
    busy_d        = (state_d != IDLE) && (state_d != ERR);
    cpu_restart_d = (state_d == DONE);
    mem_wre_d     = (state_d == WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      lo_q          <= '0;
      word_q        <= '0;
      words_q       <= '0;
      tmo_q         <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      cpu_run_q     <= 1'b1;
      cpu_restart_q <= 1'b0;
      mem_wre_q     <= 1'b0;
`ifdef IMEM_BOOT_CSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      lo_q          <= lo_d;
      word_q        <= word_d;
      words_q       <= words_d;
      tmo_q         <= tmo_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      cpu_run_q     <= cpu_run_d;
      cpu_restart_q <= cpu_restart_d;
      mem_wre_q     <= mem_wre_d;
`ifdef IMEM_BOOT_CSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  // BSRAM address follows the CPU except during the single write cycle.
  assign mem_ad       = (state_q == WRITE) ? addr_q : cpu_pc;
  assign mem_din      = word_q;
  assign mem_wre      = mem_wre_q;
  assign mem_ce       = 1'b1;
  assign cpu_run      = cpu_run_q;
  assign cpu_restart  = cpu_restart_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Testbench for imem_boot_ctrl: directed UART frames, BSRAM writes checked
// by a scoreboard monitor, control outputs checked by the stimulus thread.
module tb_imem_boot_ctrl;

  localparam int unsigned ADDR_W = 11;
`ifdef IMEM_BOOT_CSUM_EN
  localparam bit CSUM_ON   = 1'b1;
  localparam int LAST_GAP_DONE = 0;
`else
  localparam bit CSUM_ON   = 1'b0;
  localparam int LAST_GAP_DONE = 1;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [15:0]       d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] cpu_pc;
  logic [ADDR_W-1:0] mem_ad;
  logic [15:0]       mem_din;
  logic              mem_wre, mem_ce, cpu_run, cpu_restart, busy, err;
  logic [7:0]        words_loaded;

  int  n_chk = 0;
  int  n_fail = 0;
  int  restart_cnt = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  imem_boot_ctrl #(
    .ADDR_W    (ADDR_W),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (24'd40)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .cpu_pc       (cpu_pc),
    .mem_ad       (mem_ad),
    .mem_din      (mem_din),
    .mem_wre      (mem_wre),
    .mem_ce       (mem_ce),
    .cpu_run      (cpu_run),
    .cpu_restart  (cpu_restart),
    .busy         (busy),
    .err          (err),
    .words_loaded (words_loaded)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every BSRAM write must match the next expected one.
  always @(negedge clk) begin
    if (rst === 1'b0 && mem_wre === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", mem_ad, mem_din);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_ad), 32'(e.a));
        check("wr_data", 32'(mem_din), 32'(e.d));
      end
      check("wr_cpu_held", 32'(cpu_run), 32'd0);
    end
    if (rst === 1'b0 && cpu_restart === 1'b1) begin
      restart_cnt++;
      check("restart_with_run", 32'(cpu_run), 32'd1);
    end
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // d holds LEN followed by the data bytes; checksum appended when enabled.
  task automatic send_frame(input logic [7:0] d[$], input int zero_idx,
                            input int last_gap, input logic [7:0] csum_adj);
    logic [7:0] sum;
    int gap;
    sum = 8'h00;
    send_byte(8'hA5, 2);
    for (int i = 0; i < d.size(); i++) begin
      sum = sum + d[i];
      if (i == zero_idx) gap = 0;
      else if (i == d.size() - 1 && !CSUM_ON) gap = last_gap;
      else gap = 2;
      send_byte(d[i], gap);
    end
    if (CSUM_ON) send_byte(sum + csum_adj, last_gap);
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [7:0] q[$];
    int rc;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    cpu_pc = 11'h155;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_cpu_run", 32'(cpu_run), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_wre", 32'(mem_wre), 32'd0);
    check("rst_din", 32'(mem_din), 32'd0);
    check("rst_restart", 32'(cpu_restart), 32'd0);
    check("rst_ce", 32'(mem_ce), 32'd1);
    check("rst_mem_ad", 32'(mem_ad), 32'h155);
    rst = 1'b0;
    @(posedge clk); #1;
    cpu_pc = 11'h2AA;
    #1;
    check("idle_mem_ad_follows_pc", 32'(mem_ad), 32'h2AA);

    // Test 1: two-word frame, exact write/restart latency
    rc = restart_cnt;
    push_wr(11'd0, 16'h1234);
    push_wr(11'd1, 16'hABCD);
    q = '{8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
    send_frame(q, -1, 0, 8'h00);
`ifndef IMEM_BOOT_CSUM_EN
    check("t1_wre_latency", 32'(mem_wre), 32'd1);
    check("t1_wr_addr", 32'(mem_ad), 32'd1);
    @(posedge clk); #1;
`endif
    check("t1_restart", 32'(cpu_restart), 32'd1);
    check("t1_run", 32'(cpu_run), 32'd1);
    @(posedge clk); #1;
    check("t1_restart_one_cycle", 32'(cpu_restart), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_words", 32'(words_loaded), 32'd2);
    check("t1_err", 32'(err), 32'd0);
    check("t1_restart_cnt", 32'(restart_cnt - rc), 32'd1);
    check("t1_writes_done", 32'(exp_q.size()), 32'd0);

    // Test 2: zero-length frame
    rc = restart_cnt;
    send_byte(8'hA5, 2);
    check("t2_run_held", 32'(cpu_run), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    send_byte(8'h00, 2);
    check("t2_run_back", 32'(cpu_run), 32'd1);
    check("t2_busy_clr", 32'(busy), 32'd0);
    check("t2_err", 32'(err), 32'd0);
    check("t2_no_restart", 32'(restart_cnt - rc), 32'd0);
    check("t2_words", 32'(words_loaded), 32'd0);

    // Test 3: timeout mid-frame, then recovery via sync
    push_wr(11'd0, 16'h2211);
    send_byte(8'hA5, 2);
    send_byte(8'h03, 2);
    send_byte(8'h11, 2);
    send_byte(8'h22, 2);
    repeat (60) @(posedge clk);
    #1;
    check("t3_err", 32'(err), 32'd1);
    check("t3_run_held", 32'(cpu_run), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    push_wr(11'd0, 16'hBEEF);
    q = '{8'h01, 8'hEF, 8'hBE};
    send_frame(q, -1, 3, 8'h00);
    check("t3_err_clr", 32'(err), 32'd0);
    check("t3_run", 32'(cpu_run), 32'd1);
    check("t3_words", 32'(words_loaded), 32'd1);
    check("t3_writes_done", 32'(exp_q.size()), 32'd0);

    // Test 4a: byte arriving in the WRITE cycle is parked, not lost
    push_wr(11'd0, 16'h1234);
    push_wr(11'd1, 16'h5678);
    q = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56};
    send_frame(q, 2, 3, 8'h00);
    check("t4a_words", 32'(words_loaded), 32'd2);
    check("t4a_err", 32'(err), 32'd0);
    check("t4a_writes_done", 32'(exp_q.size()), 32'd0);

    // Test 4b: sync byte arriving in the DONE cycle starts the next frame
    rc = restart_cnt;
    push_wr(11'd0, 16'hBBAA);
    push_wr(11'd0, 16'hDDCC);
    q = '{8'h01, 8'hAA, 8'hBB};
    send_frame(q, -1, LAST_GAP_DONE, 8'h00);
    q = '{8'h01, 8'hCC, 8'hDD};
    send_frame(q, -1, 3, 8'h00);
    check("t4b_restarts", 32'(restart_cnt - rc), 32'd2);
    check("t4b_err", 32'(err), 32'd0);
    check("t4b_run", 32'(cpu_run), 32'd1);
    check("t4b_writes_done", 32'(exp_q.size()), 32'd0);

`ifdef IMEM_BOOT_CSUM_EN
    // Test 5: checksum good (04) then bad (05)
    rc = restart_cnt;
    push_wr(11'd0, 16'h0201);
    send_byte(8'hA5, 2);
    send_byte(8'h01, 2);
    send_byte(8'h01, 2);
    send_byte(8'h02, 2);
    send_byte(8'h04, 3);
    check("t5_good_restart", 32'(restart_cnt - rc), 32'd1);
    check("t5_good_err", 32'(err), 32'd0);
    push_wr(11'd0, 16'h0201);
    send_byte(8'hA5, 2);
    send_byte(8'h01, 2);
    send_byte(8'h01, 2);
    send_byte(8'h02, 2);
    send_byte(8'h05, 3);
    check("t5_bad_err", 32'(err), 32'd1);
    check("t5_bad_run", 32'(cpu_run), 32'd0);
    check("t5_bad_restart", 32'(restart_cnt - rc), 32'd1);
`endif

    // Test 6: reset after the first word of a two-word frame
    push_wr(11'd0, 16'h1234);
    send_byte(8'hA5, 2);
    send_byte(8'h02, 2);
    send_byte(8'h34, 2);
    send_byte(8'h12, 2);
    check("t6_mid_busy", 32'(busy), 32'd1);
    check("t6_mid_words", 32'(words_loaded), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_run", 32'(cpu_run), 32'd1);
    check("t6_err", 32'(err), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_words", 32'(words_loaded), 32'd0);
    check("t6_wre", 32'(mem_wre), 32'd0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t6_idle_run", 32'(cpu_run), 32'd1);
    check("final_writes_done", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
